// File: rtl/button_bank.sv
// Multi-channel push-button front end: synchroniser, debounce, press/release strobes,
// short-press toggle, long-press hold flag and auto-repeat strobe per channel.
module button_bank #(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES     = 12500000,
  parameter int REPEAT_CYCLES   = 2500000,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BUTTONS-1:0] buttons_in,
  input  logic [NUM_BUTTONS-1:0] repeat_en,
  output logic [NUM_BUTTONS-1:0] level,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] release_pulse,
  output logic [NUM_BUTTONS-1:0] toggle,
  output logic [NUM_BUTTONS-1:0] hold,
  output logic [NUM_BUTTONS-1:0] repeat_pulse
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} hold_state_t;

  logic [NUM_BUTTONS-1:0] pin_norm;
  logic [NUM_BUTTONS-1:0] sync_meta;
  logic [NUM_BUTTONS-1:0] sync_q;

  // Pins are normalised to 1 = pressed before the synchroniser, so reset value 0 means unpressed.
  assign pin_norm = (ACTIVE_LOW != 0) ? ~buttons_in : buttons_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= pin_norm;
      sync_q    <= sync_meta;
    end
  end

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
    logic [DEB_W-1:0]  deb_cnt;
    logic              level_q;
    logic              press_q;
    logic              release_q;
    logic              commit;
    logic              press_commit;
    logic              release_commit;
    hold_state_t       state_q;
    hold_state_t       state_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic [REP_W-1:0]  rep_cnt_q;
    logic [REP_W-1:0]  rep_cnt_d;
    logic              toggle_q;
    logic              toggle_d;
    logic              rep_pulse_q;
    logic              rep_pulse_d;

    assign commit         = (sync_q[i] != level_q) && (deb_cnt == DEB_LAST);
    assign press_commit   = commit && !level_q;
    assign release_commit = commit && level_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        deb_cnt   <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= press_commit;
        release_q <= release_commit;
        if (sync_q[i] == level_q) begin
          deb_cnt <= '0;
        end else if (commit) begin
          level_q <= sync_q[i];
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + DEB_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q     <= IDLE;
        hold_cnt_q  <= '0;
        rep_cnt_q   <= '0;
        toggle_q    <= 1'b0;
        rep_pulse_q <= 1'b0;
      end else begin
        state_q     <= state_d;
        hold_cnt_q  <= hold_cnt_d;
        rep_cnt_q   <= rep_cnt_d;
        toggle_q    <= toggle_d;
        rep_pulse_q <= rep_pulse_d;
      end
    end

    // Release always wins over the hold threshold and over a repeat wrap on the same edge.
    always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      rep_cnt_d   = rep_cnt_q;
      toggle_d    = toggle_q;
      rep_pulse_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (press_commit) begin
            state_d    = PRESSED;
            hold_cnt_d = '0;
          end
        end
        PRESSED: begin
          if (release_commit) begin
            state_d  = IDLE;
            toggle_d = ~toggle_q;
          end else if (hold_cnt_q == HOLD_LAST) begin
            state_d     = HELD;
            rep_cnt_d   = '0;
            rep_pulse_d = repeat_en[i];
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
        HELD: begin
          if (release_commit) begin
            state_d = IDLE;
          end else if (rep_cnt_q == REP_LAST) begin
            rep_cnt_d   = '0;
            rep_pulse_d = repeat_en[i];
          end else begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    assign level[i]         = level_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
    assign toggle[i]        = toggle_q;
    assign hold[i]          = (state_q == HELD);
    assign repeat_pulse[i]  = rep_pulse_q;
  end

endmodule

// File: tb/tb_button_bank.sv
// Scoreboard bench for button_bank: stimulus pushes expected output snapshots keyed by
// clock edge; a negedge monitor compares them and flags any unannounced output event.
module tb_button_bank;

  logic       clk;
  logic       rst_n;
  logic [1:0] buttons_in;
  logic [1:0] repeat_en;
  logic [1:0] level;
  logic [1:0] press_pulse;
  logic [1:0] release_pulse;
  logic [1:0] toggle;
  logic [1:0] hold;
  logic [1:0] repeat_pulse;
  logic [11:0] outs;

  typedef struct {
    int          cyc;
    string       name;
    logic [11:0] val;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       ent;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [1:0] prev_hold = '0;
  logic       trig;
  int         e;

  button_bank #(
    .NUM_BUTTONS    (2),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10),
    .REPEAT_CYCLES  (3),
    .ACTIVE_LOW     (0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .buttons_in   (buttons_in),
    .repeat_en    (repeat_en),
    .level        (level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .toggle       (toggle),
    .hold         (hold),
    .repeat_pulse (repeat_pulse)
  );

  assign outs = {level, press_pulse, release_pulse, toggle, hold, repeat_pulse};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] pack(input logic [1:0] l, input logic [1:0] p,
                                       input logic [1:0] r, input logic [1:0] t,
                                       input logic [1:0] h, input logic [1:0] q);
    return {l, p, r, t, h, q};
  endfunction

  task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got lvl/prs/rel/tog/hld/rep=%b required %b", name, act, exp_v);
    end
  endtask

  task automatic expectAt(input int c, input string name, input logic [11:0] v);
    exp_t x;
    x.cyc  = c;
    x.name = name;
    x.val  = v;
    exp_q.push_back(x);
  endtask

  task automatic applyStimulus(input int edges, input logic [1:0] pins, input logic [1:0] ren);
    repeat (edges) @(posedge clk);
    #1;
    buttons_in = pins;
    repeat_en  = ren;
  endtask

  // Monitor: compares the scheduled snapshot for this edge, otherwise any pulse or hold change is an error.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = '0;
    end else begin
      trig = (|press_pulse) || (|release_pulse) || (|repeat_pulse) || (hold != prev_hold);
      prev_hold = hold;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        ent = exp_q.pop_front();
        checks++;
        errors++;
        $display("[TB] FAIL %s: snapshot for edge %0d never sampled, required %b", ent.name, ent.cyc, ent.val);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        ent = exp_q.pop_front();
        checkOutput(ent.name, outs, ent.val);
      end else if (trig) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_event at edge %0d: got %b required no pulse/hold change", cyc, outs);
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    buttons_in = 2'b00;
    repeat_en  = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", outs, 12'b0);
    rst_n = 1'b1;

    // Clean short press on ch0; release commit lands on the hold threshold edge
    applyStimulus(3, 2'b01, 2'b00);
    e = cyc + 1;
    expectAt(e + 5,  "press_ch0",         pack(2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    expectAt(e + 10, "level_mid_ch0",     pack(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    applyStimulus(10, 2'b00, 2'b00);
    expectAt(e + 15, "release_ch0_short", pack(2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00));

    // Glitches one cycle short of the debounce window never commit
    applyStimulus(8, 2'b00, 2'b00);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(3, 2'b01, 2'b00);
      applyStimulus(3, 2'b00, 2'b00);
    end
    applyStimulus(6, 2'b00, 2'b00);
    expectAt(cyc + 1, "glitch_no_commit", pack(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00));

    // Long press ch1 with repeat enabled; release edge coincides with a repeat slot
    applyStimulus(2, 2'b10, 2'b10);
    e = cyc + 1;
    expectAt(e + 5,  "press_ch1",   pack(2'b10, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00));
    expectAt(e + 15, "hold_ch1",    pack(2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10));
    expectAt(e + 18, "repeat1_ch1", pack(2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10));
    expectAt(e + 21, "repeat2_ch1", pack(2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10));
    expectAt(e + 24, "repeat3_ch1", pack(2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10));
    expectAt(e + 27, "repeat4_ch1", pack(2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10));
    applyStimulus(25, 2'b00, 2'b10);
    expectAt(e + 30, "release_ch1_held", pack(2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00));

    // repeat_en dropped during HELD, then restored on the original grid
    applyStimulus(8, 2'b10, 2'b10);
    e = cyc + 1;
    expectAt(e + 5,  "press_ch1_b",  pack(2'b10, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00));
    expectAt(e + 15, "hold_ch1_b",   pack(2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10));
    expectAt(e + 18, "repeat_b1",    pack(2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10));
    applyStimulus(19, 2'b10, 2'b00);
    expectAt(e + 21, "repeat_off_1", pack(2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00));
    expectAt(e + 24, "repeat_off_2", pack(2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00));
    applyStimulus(6, 2'b10, 2'b10);
    expectAt(e + 27, "repeat_resume", pack(2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10));
    applyStimulus(3, 2'b00, 2'b10);
    expectAt(e + 30, "repeat_b2",     pack(2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10));
    expectAt(e + 33, "release_ch1_b", pack(2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00));

    // Both channels pressed together, ch0 released alone, ch1 goes on to hold
    applyStimulus(8, 2'b11, 2'b00);
    e = cyc + 1;
    expectAt(e + 5, "press_both", pack(2'b11, 2'b11, 2'b00, 2'b01, 2'b00, 2'b00));
    applyStimulus(7, 2'b10, 2'b00);
    expectAt(e + 12, "release_ch0_only", pack(2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00));
    expectAt(e + 15, "hold_ch1_norep",   pack(2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00));
    applyStimulus(14, 2'b00, 2'b00);
    expectAt(e + 26, "release_ch1_c",    pack(2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00));

    // Reset while ch0 HELD with pin still pressed
    applyStimulus(8, 2'b01, 2'b01);
    e = cyc + 1;
    expectAt(e + 5,  "press_ch0_d",  pack(2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    expectAt(e + 15, "hold_ch0_d",   pack(2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01));
    expectAt(e + 18, "repeat_ch0_d", pack(2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01));
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_async_clear", outs, 12'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    e = cyc + 1;
    expectAt(e + 5,  "press_after_reset", pack(2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    expectAt(e + 10, "no_hold_carryover", pack(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    expectAt(e + 15, "hold_after_reset",  pack(2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01));
    expectAt(e + 18, "repeat_e1",         pack(2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01));
    expectAt(e + 21, "repeat_e2",         pack(2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01));
    applyStimulus(19, 2'b00, 2'b01);
    expectAt(e + 24, "release_no_repeat", pack(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00));

    applyStimulus(10, 2'b00, 2'b00);
    while (exp_q.size() > 0) begin
      ent = exp_q.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL %s: snapshot for edge %0d still pending, required %b", ent.name, ent.cyc, ent.val);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
